// File: rtl/grid_neighbor_engine.sv
// grid_neighbor_engine
//   Loads a WIDTH x HEIGHT occupancy grid one bit per cycle, then scans it
//   to count occupied cells with fewer than THRESH occupied 8-neighbours.
//   Mode 0 runs a single pass and leaves the grid untouched. Mode 1 removes
//   every accessible cell after each pass and repeats until a pass removes
//   nothing. Each pass sees the grid as it stood when the pass began.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/in_bit  grid bit stream, row-major, row 0 col 0 first
//   in_ready         high while loading
//   reload           IDLE/DONE -> LOAD
//   start            IDLE/DONE -> SCAN (reload wins in DONE)
//   mode             0 = single pass, 1 = iterate to fixed point
//   busy             high while scanning
//   done             high while results are final
//   result           accessible count (mode 0) or total removed (mode 1)
//   passes           passes that removed cells (saturating)
module grid_neighbor_engine #(
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 10,
  parameter int THRESH   = 4,
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_bit,
  output logic                in_ready,
  input  logic                reload,
  input  logic                start,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic [15:0]         passes
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]        grid;
  logic [N-1:0]        mark;
  logic [N-1:0]        mark_nxt;
  logic [IDX_W-1:0]    load_idx;
  logic [IDX_W-1:0]    scan_idx;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic                mode_r;
  logic [RESULT_W-1:0] pass_removed;
  logic [3:0]          nbr_cnt;
  logic                accessible;
  logic                last_cell;
  logic                pass_hit;
  logic                load_last;
  logic                launch;

  // Occupied-neighbour count of the cell under the scan pointer.
  always_comb begin
    nbr_cnt = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        int nr;
        int nc;
        nr = int'(row) + int'(dr) - 1;
        nc = int'(col) + int'(dc) - 1;
        if ((dr != 1 || dc != 1) && nr >= 0 && nr < HEIGHT && nc >= 0 && nc < WIDTH) begin
          if (grid[IDX_W'(nr * WIDTH + nc)]) begin
            nbr_cnt = nbr_cnt + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    accessible = (state == S_SCAN) && grid[scan_idx] && (nbr_cnt < 4'(THRESH));
    last_cell  = (scan_idx == LAST_IDX);
    pass_hit   = (pass_removed != '0) || accessible;
    load_last  = in_valid && (state == S_LOAD) && (load_idx == LAST_IDX);
    launch     = start && ((state == S_IDLE) || ((state == S_DONE) && !reload));
    mark_nxt   = mark;
    if (accessible) begin
      mark_nxt[scan_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (load_last) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (start) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (last_cell && (!mode_r || !pass_hit)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (reload) state_nxt = S_LOAD;
        else if (start) state_nxt = S_SCAN;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOAD;
      load_idx     <= '0;
      scan_idx     <= '0;
      row          <= '0;
      col          <= '0;
      mode_r       <= 1'b0;
      mark         <= '0;
      pass_removed <= '0;
      result       <= '0;
      passes       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            grid[load_idx] <= in_bit;
            load_idx       <= load_last ? '0 : load_idx + IDX_W'(1);
          end
        end
        S_IDLE, S_DONE: begin
          if (launch) begin
            result       <= '0;
            passes       <= '0;
            mode_r       <= mode;
            scan_idx     <= '0;
            row          <= '0;
            col          <= '0;
            mark         <= '0;
            pass_removed <= '0;
          end
        end
        S_SCAN: begin
          mark <= mark_nxt;
          if (accessible) begin
            result       <= result + RESULT_W'(1);
            pass_removed <= pass_removed + RESULT_W'(1);
          end
          if (last_cell) begin
            scan_idx     <= '0;
            row          <= '0;
            col          <= '0;
            mark         <= '0;
            pass_removed <= '0;
            if (!mode_r) begin
              passes <= pass_hit ? 16'd1 : 16'd0;
            end else if (pass_hit) begin
              // Removals land only here, so every count in the pass used the
              // grid as it stood at the pass start.
              grid <= grid & ~mark_nxt;
              if (passes != '1) passes <= passes + 16'd1;
            end
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_neighbor_engine.sv
// Directed bench for grid_neighbor_engine: four instances of different grid
// sizes share the stimulus bus; sel steers in_valid/start/reload to one of
// them and picks which outputs are observed.
module tb_grid_neighbor_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       start = 1'b0;
  logic       reload = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [3:0]  vv, st, rl, rdy, bsy, dn;
  logic [31:0] res0, res1, res2, res3;
  logic [15:0] pas0, pas1, pas2, pas3;

  assign vv = in_valid ? (4'b0001 << sel) : 4'b0000;
  assign st = start    ? (4'b0001 << sel) : 4'b0000;
  assign rl = reload   ? (4'b0001 << sel) : 4'b0000;

  grid_neighbor_engine #(.WIDTH(3), .HEIGHT(3), .THRESH(4), .RESULT_W(32)) u_g3 (
    .clk(clk), .rst(rst), .in_valid(vv[0]), .in_bit(in_bit), .in_ready(rdy[0]),
    .reload(rl[0]), .start(st[0]), .mode(mode), .busy(bsy[0]), .done(dn[0]),
    .result(res0), .passes(pas0));

  grid_neighbor_engine #(.WIDTH(10), .HEIGHT(10), .THRESH(4), .RESULT_W(32)) u_g10 (
    .clk(clk), .rst(rst), .in_valid(vv[1]), .in_bit(in_bit), .in_ready(rdy[1]),
    .reload(rl[1]), .start(st[1]), .mode(mode), .busy(bsy[1]), .done(dn[1]),
    .result(res1), .passes(pas1));

  grid_neighbor_engine #(.WIDTH(1), .HEIGHT(1), .THRESH(4), .RESULT_W(32)) u_g1 (
    .clk(clk), .rst(rst), .in_valid(vv[2]), .in_bit(in_bit), .in_ready(rdy[2]),
    .reload(rl[2]), .start(st[2]), .mode(mode), .busy(bsy[2]), .done(dn[2]),
    .result(res2), .passes(pas2));

  grid_neighbor_engine #(.WIDTH(4), .HEIGHT(5), .THRESH(4), .RESULT_W(32)) u_g45 (
    .clk(clk), .rst(rst), .in_valid(vv[3]), .in_bit(in_bit), .in_ready(rdy[3]),
    .reload(rl[3]), .start(st[3]), .mode(mode), .busy(bsy[3]), .done(dn[3]),
    .result(res3), .passes(pas3));

  logic        cur_rdy, cur_busy, cur_done;
  logic [31:0] cur_res;
  logic [15:0] cur_pas;

  always_comb begin
    cur_rdy  = rdy[sel];
    cur_busy = bsy[sel];
    cur_done = dn[sel];
    case (sel)
      2'd0:    begin cur_res = res0; cur_pas = pas0; end
      2'd1:    begin cur_res = res1; cur_pas = pas1; end
      2'd2:    begin cur_res = res2; cur_pas = pas2; end
      default: begin cur_res = res3; cur_pas = pas3; end
    endcase
  end

  int w_of [4] = '{3, 10, 1, 4};
  int h_of [4] = '{3, 10, 1, 5};

  typedef struct {
    int    sel;
    bit    do_load;
    string g;
    bit    mode;
    int    exp_res;
    int    exp_pas;
    bit    chk_pas;
    int    npass;
  } vec_t;

  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail = 0;
  string puzzle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (sel %0d): got %0d, expected %0d", name, sel, act, exp);
    end
  endtask

  function automatic vec_t mk(input int s, input bit ld, input string g, input bit m,
                              input int er, input int ep, input bit cp, input int np);
    vec_t v;
    v.sel = s; v.do_load = ld; v.g = g; v.mode = m;
    v.exp_res = er; v.exp_pas = ep; v.chk_pas = cp; v.npass = np;
    return v;
  endfunction

  function automatic logic bitc(input byte c);
    return (c == "@" || c == "1");
  endfunction

  task automatic load_grid(input string g);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < g.len() && guard < 4000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_bit   = bitc(g[idx]);
      // start/reload mid-load must have no effect
      start    = (idx == g.len() / 2);
      reload   = start;
      acc      = in_valid && cur_rdy;
      @(negedge clk);
      guard++;
      if (acc) idx++;
    end
    start    = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    check("load_count", idx, g.len());
    check("in_ready_drop", {31'd0, cur_rdy}, 0);
    @(negedge clk);
    check("in_ready_stays_low", {31'd0, cur_rdy}, 0);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cycles;
    int limit;
    sel = v.sel[1:0];
    if (v.do_load) begin
      if (!cur_rdy) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
      check("reload_ready", {31'd0, cur_rdy}, 1);
      load_grid(v.g);
    end
    mode  = v.mode;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    check("busy_after_start", {31'd0, cur_busy}, 1);
    check("done_low_in_scan", {31'd0, cur_done}, 0);
    if (cur_busy) begin
      start  = 1'b1;
      reload = 1'b1;
      mode   = ~v.mode;
      @(negedge clk);
      start  = 1'b0;
      reload = 1'b0;
      cycles++;
    end
    limit = v.npass * (w_of[v.sel] * h_of[v.sel] + 2 * w_of[v.sel] + 8) + 2;
    while (!cur_done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    check("done_within_bound", {31'd0, cur_done}, 1);
    check("busy_clear_at_done", {31'd0, cur_busy}, 0);
    check("result", cur_res, v.exp_res);
    if (v.chk_pas) check("passes", {16'd0, cur_pas}, v.exp_pas);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    puzzle = {"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
              ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."};

    vecs.push_back(mk(0, 1, "111111111", 0, 4, 1, 1, 1));
    vecs.push_back(mk(0, 0, "",          0, 4, 1, 1, 1));
    vecs.push_back(mk(0, 1, "111111111", 1, 9, 3, 1, 4));
    vecs.push_back(mk(0, 0, "",          0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, puzzle,      0, 13, 1, 1, 1));
    vecs.push_back(mk(1, 1, puzzle,      1, 43, 0, 0, 12));
    vecs.push_back(mk(2, 1, "0",         0, 0, 0, 1, 1));
    vecs.push_back(mk(2, 0, "",          1, 0, 0, 1, 1));
    vecs.push_back(mk(2, 1, "1",         1, 1, 1, 1, 2));
    vecs.push_back(mk(2, 0, "",          0, 0, 0, 1, 1));
    vecs.push_back(mk(3, 1, "00000000000000000000", 0, 0, 0, 1, 1));
    vecs.push_back(mk(3, 0, "",          1, 0, 0, 1, 1));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #0;
      check("reset_in_ready", {31'd0, cur_rdy}, 1);
      check("reset_busy", {31'd0, cur_busy}, 0);
      check("reset_done", {31'd0, cur_done}, 0);
      check("reset_result", cur_res, 0);
      check("reset_passes", {16'd0, cur_pas}, 0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a multi-pass scan.
    sel    = 2'd1;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    load_grid(puzzle);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_before_rst", {31'd0, cur_busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_scan_in_ready", {31'd0, cur_rdy}, 1);
    check("rst_scan_busy", {31'd0, cur_busy}, 0);
    check("rst_scan_done", {31'd0, cur_done}, 0);
    check("rst_scan_result", cur_res, 0);
    check("rst_scan_passes", {16'd0, cur_pas}, 0);
    run_vec(mk(1, 1, puzzle, 0, 13, 1, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
